// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with a two-entry skid buffer and synchronous flush.
// Defining PIPE_STAGE_PERF_EN adds the stall_cnt port and its saturating backpressure counter.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  if (WIDTH < 1 || CNT_W < 1) begin : g_param_check
    $error("pipe_stage_reg: WIDTH and CNT_W must be at least 1");
  end

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             acc_in;
  logic             main_free;

  assign acc_in    = in_valid & ~skid_valid;
  // Main is free when it is empty or its beat is taken downstream on this edge.
  assign main_free = ~main_valid | out_ready;

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign in_ready  = ~skid_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      main_valid <= skid_valid | acc_in;
      skid_valid <= 1'b0;
    end else if (acc_in) begin
      skid_valid <= 1'b1;
    end
  end

  // Payload moves only on an accepted beat, so in_data is ignored while in_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else if (!flush) begin
      if (main_free) begin
        if (skid_valid)  main_data <= skid_data;
        else if (acc_in) main_data <= in_data;
      end else if (acc_in) begin
        skid_data <= in_data;
      end
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && !(&stall_q)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: expected beats queued on acceptance, compared on delivery.
module tb_pipe_stage_reg;
  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         flush = 1'b0;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  int            stall_exp = 0;
`endif

  logic [W-1:0] sb[$];
  int n_checks = 0;
  int n_errs   = 0;
  int beats    = 0;

  pipe_stage_reg #(
    .WIDTH    (W),
    .RESET_VAL(8'h00),
    .CNT_W    (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .flush    (flush)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply the current inputs for one clock edge, update the model, then check the stage.
  task automatic step();
    logic [W-1:0] e;
    #1;
    if (out_valid && out_ready) begin
      beats++;
      if (sb.size() == 0) chk("spurious_beat", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("beat_data", out_data, e);
      end
    end
    if (flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(in_data);
`ifdef PIPE_STAGE_PERF_EN
    if (out_valid && !out_ready && stall_exp < 15) stall_exp++;
`endif
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, sb.size() > 0);
    chk("in_ready", in_ready, sb.size() < 2);
    if (sb.size() > 0) chk("out_data", out_data, sb[0]);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", stall_cnt, stall_exp);
`endif
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    step();
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_in_ready", in_ready, 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    sb.delete();
`ifdef PIPE_STAGE_PERF_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    stall_exp = 0;
`endif
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    chk("init_out_valid", out_valid, 32'd0);
    chk("init_in_ready", in_ready, 32'd1);
    chk("init_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming at full rate
    drive(1'b1, 8'h11, 1'b1, 1'b0);
    chk("t2_first", out_data, 32'h11);
    drive(1'b1, 8'h22, 1'b1, 1'b0);
    chk("t2_second", out_data, 32'h22);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    chk("t2_third", out_data, 32'h33);
    chk("t2_ready", in_ready, 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset with a beat held
    drive(1'b1, 8'hE1, 1'b0, 1'b0);
    mid_reset();

    // Backpressure fills the skid
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    chk("t3_hold", out_data, 32'hA1);
    chk("t3_full", in_ready, 32'd0);
    drive(1'b0, 8'h5A, 1'b0, 1'b0);
    chk("t3_stable", out_data, 32'hA1);
    beats = 0;
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_next", out_data, 32'hA2);
    chk("t3_ready_back", in_ready, 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3_two_beats", beats, 32'd2);
    chk("t3_empty", out_valid, 32'd0);

    // Flush with both entries full
    drive(1'b1, 8'hB1, 1'b0, 1'b0);
    drive(1'b1, 8'hB2, 1'b0, 1'b0);
    drive(1'b1, 8'hB3, 1'b0, 1'b1);
    chk("t4_flushed", out_valid, 32'd0);
    chk("t4_ready", in_ready, 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Flush drops a beat accepted in the same cycle but delivers the outgoing one
    drive(1'b1, 8'hD1, 1'b0, 1'b0);
    drive(1'b1, 8'hD2, 1'b1, 1'b1);
    chk("t4_drop", out_valid, 32'd0);

    // Same-cycle handoff
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    drive(1'b1, 8'hC2, 1'b1, 1'b0);
    chk("t5_valid", out_valid, 32'd1);
    chk("t5_data", out_data, 32'hC2);
    chk("t5_skid_empty", in_ready, 32'd1);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic, garbage payload while invalid
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
    end
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
    // Stall counter saturation, flush immunity, reset clear
    mid_reset();
    drive(1'b1, 8'hF1, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_saturated", stall_cnt, 32'd15);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t6_after_flush", stall_cnt, 32'd15);
    mid_reset();
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline register stage; successor to the plain enable-gated 32-bit register.
- Adds a valid/ready handshake, a flush input, and a two-entry skid buffer so the stage sustains one beat per cycle under backpressure.
- in_ready has no combinational path from out_ready.
- Placed between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and on any registered datapath needing stall/flush.

Parameters:
WIDTH, 32, payload width in bits (>=1)
RESET_VAL, 0, value loaded into both data registers on reset (WIDTH bits)
CNT_W, 16, stall counter width; used only when PIPE_STAGE_PERF_EN is defined

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream beat present
in_ready  output  1  stage can accept a beat this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  stage holds a beat for downstream
out_ready  input  1  downstream accepts out_data this cycle
out_data  output  WIDTH  payload to downstream
flush  input  1  synchronous discard of all held beats
stall_cnt  output  CNT_W  backpressure cycle count (present only with PIPE_STAGE_PERF_EN)

Behaviour:
- State: main_valid, main_data, skid_valid, skid_data.
- Outputs: out_valid = main_valid; out_data = main_data; in_ready = ~skid_valid. All are driven from flops only.
- Events: acc_in = in_valid & in_ready; acc_out = main_valid & out_ready.
- Reset (rst_n low, asynchronous, takes effect immediately regardless of clk):
  - main_valid = skid_valid = 0.
  - main_data = skid_data = RESET_VAL.
  - Hence out_valid = 0, out_data = RESET_VAL, in_ready = 1.
  - Reset deassertion is synchronised externally.
- Per-edge priority, highest first:
  1. flush = 1:
     - main_valid <= 0 and skid_valid <= 0.
     - Data registers hold.
     - A beat accepted (acc_in) in the flush cycle is dropped.
     - A beat taken downstream (acc_out) in the flush cycle counts as delivered.
  2. main empty or acc_out (main drains):
     - If skid_valid: main <= skid; skid_valid <= 0. in_ready was 0, so no acc_in is possible.
     - Else: main_valid <= acc_in; if acc_in, main_data <= in_data.
  3. Main held (main_valid & ~out_ready):
     - If acc_in: skid_data <= in_data; skid_valid <= 1.
- Latency: 1 cycle from acc_in to out_valid when the skid is empty.
- Throughput: 1 beat/cycle with out_ready held high.
- Ordering: beats leave strictly in acceptance order, with no duplication or loss except by flush or reset.
- Capacity: 2 beats. in_ready falls the cycle after the skid fills and rises the cycle after the skid drains into main.
- out_data is stable while out_valid & ~out_ready.
- in_data is ignored when in_valid = 0. X on in_data while in_valid = 0 must not propagate to out_data.
- Simultaneous acc_in and acc_out with the skid empty: main is replaced by the new beat, and out_valid stays 1.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - stall_cnt port exists.
  - Increments by 1 on each edge where out_valid & ~out_ready, saturating at 2^CNT_W-1.
  - Cleared only by reset, not by flush.
- Undefined: port and counter logic are absent; behaviour is otherwise identical.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle with a beat held -> out_valid=0, out_data=0, in_ready=1 immediately, before the next edge.
2. Streaming: out_ready=1; in_data 0x11, 0x22, 0x33 on consecutive cycles with in_valid=1 -> out_data 0x11, 0x22, 0x33 one cycle later each; in_ready stays 1 throughout.
3. Backpressure: out_ready=0; send 0xA1 then 0xA2 -> out_data holds 0xA1, in_ready=0 after 0xA2 is accepted. Then raise out_ready -> 0xA1 transfers, 0xA2 appears next cycle, in_ready=1 again, exactly two output beats.
4. Flush: both entries full (0xB1 main, 0xB2 skid); pulse flush with in_valid=1, in_data=0xB3 -> next cycle out_valid=0, in_ready=1; 0xB3 never appears.
5. Same-cycle handoff: main holds 0xC1, skid empty, out_ready=1, in_valid=1, in_data=0xC2 -> next cycle out_valid=1, out_data=0xC2, skid_valid=0.
6. PIPE_STAGE_PERF_EN with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 (saturated); flush -> stall_cnt stays 15; reset -> 0.
